adsr_envelope: RTL and testbench

- Per-voice ADSR envelope generator and VCA; sits directly downstream of the Oscillator and consumes its 16-bit signed `wave` sample.
- Runs on the same 48 kHz sample clock and processes one sample per `clk`.
- Produces the amplitude-shaped voice sample for the mixer.
- Gate driven by the note controller: high = key down.

---
 rtl/synth_pkg.sv | 18 +
 rtl/adsr_envelope_if.sv | 28 ++
 rtl/vca_mult.sv | 41 ++++
 rtl/adsr_envelope.sv | 102 ++++++++++
 tb/tb_adsr_envelope.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and default widths for the synth voice blocks (envelope, VCA, mixer).
package synth_pkg;

  localparam int WAVE_W_DEF = 16;
  localparam int LVL_W_DEF  = 24;
  localparam int RATE_W_DEF = 16;

  localparam logic [LVL_W_DEF-1:0] LVL_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// Control/sample bundle between the note controller/oscillator side and one envelope voice.
interface adsr_envelope_if import synth_pkg::*; #(
  parameter int WAVE_W = WAVE_W_DEF,
  parameter int LVL_W  = LVL_W_DEF,
  parameter int RATE_W = RATE_W_DEF
);

  logic                     gate;
  logic        [RATE_W-1:0] attack_rate;
  logic        [RATE_W-1:0] decay_rate;
  logic        [7:0]        sustain_level;
  logic        [RATE_W-1:0] release_rate;
  logic signed [WAVE_W-1:0] wave;
  logic signed [WAVE_W-1:0] out;
  logic        [LVL_W-1:0]  level;
  logic                     active;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate, wave,
    input  out, level, active
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate, wave,
    output out, level, active
  );

endinterface

// File: rtl/vca_mult.sv
// Signed sample times unsigned gain, scaled down by 2^B_W, with a registered output.
module vca_mult #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [A_W-1:0] a_i,
  input  logic        [B_W-1:0] b_i,
  output logic signed [A_W-1:0] p_o
);

  localparam int P_W = A_W + B_W + 1;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod;
  logic signed [A_W-1:0] p_d;
  logic signed [A_W-1:0] p_q;
  logic                  unused_prod_bits;

  assign a_ext = {{(B_W + 1){a_i[A_W-1]}}, a_i};
  assign b_ext = {{(A_W + 1){1'b0}}, b_i};
  assign prod  = a_ext * b_ext;

  // Gain stays below 2^B_W, so the arithmetic shift always fits back into A_W bits.
  assign p_d = prod[A_W+B_W-1 -: A_W];

  assign unused_prod_bits = ^{prod[P_W-1], prod[B_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator driving a VCA on the oscillator sample.
module adsr_envelope import synth_pkg::*; #(
  parameter int WAVE_W = WAVE_W_DEF,
  parameter int LVL_W  = LVL_W_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  adsr_envelope_if.slave env
);

  localparam int                GAIN_W  = 16;
  localparam logic [LVL_W-1:0]  LVL_TOP = '1;

  env_state_t               state_q, state_d;
  logic        [LVL_W-1:0]  level_q, level_d;
  logic                     gate_q;
  logic                     rise, fall;
  logic        [LVL_W-1:0]  target;
  logic        [LVL_W:0]    att_sum;
  logic        [LVL_W-1:0]  dec_step, rel_step;
  logic signed [WAVE_W-1:0] out_q;

  assign rise     = env.gate & ~gate_q;
  assign fall     = ~env.gate & gate_q;
  assign target   = {env.sustain_level, {(LVL_W - 8){1'b0}}};
  assign att_sum  = {1'b0, level_q} + {{(LVL_W + 1 - RATE_W){1'b0}}, env.attack_rate};
  assign dec_step = {{(LVL_W - RATE_W){1'b0}}, env.decay_rate};
  assign rel_step = {{(LVL_W - RATE_W){1'b0}}, env.release_rate};

  // Gate edges pre-empt the per-state update and leave the level untouched, keeping retriggers click-free.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
      state_d = RELEASE;
    end else begin
      unique case (state_q)
        IDLE: level_d = '0;
        ATTACK: begin
          if ((env.attack_rate == '0) || (att_sum >= {1'b0, LVL_TOP})) begin
            level_d = LVL_TOP;
            state_d = DECAY;
          end else begin
            level_d = att_sum[LVL_W-1:0];
          end
        end
        DECAY: begin
          if ((env.decay_rate == '0) || (level_q <= target) || ((level_q - target) <= dec_step)) begin
            level_d = target;
            state_d = SUSTAIN;
          end else begin
            level_d = level_q - dec_step;
          end
        end
        SUSTAIN: level_d = target;
        RELEASE: begin
          if ((env.release_rate == '0) || (level_q <= rel_step)) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = level_q - rel_step;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= env.gate;
    end
  end

  vca_mult #(
    .A_W(WAVE_W),
    .B_W(GAIN_W)
  ) u_vca (
    .clk  (clk),
    .rst_n(rst_n),
    .a_i  (env.wave),
    .b_i  (level_q[LVL_W-1 -: GAIN_W]),
    .p_o  (out_q)
  );

  assign env.out    = out_q;
  assign env.level  = level_q;
  assign env.active = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope against an arithmetic model of the envelope rules.
module tb_adsr_envelope;
  import synth_pkg::*;

  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  longint      m_level;
  int          m_state;
  bit          m_gq;
  logic [15:0] m_out;

  adsr_envelope_if env_if();

  adsr_envelope dut (
    .clk  (clk),
    .rst_n(rst_n),
    .env  (env_if)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_level = 0;
    m_state = S_IDLE;
    m_gq    = 1'b0;
    m_out   = '0;
  endfunction

  // One sample: predict from the inputs in place now, then advance past the clock edge.
  task automatic applyStimulus();
    longint tgt, lvl, ar, dr, rr, p;
    int     st;
    bit     g;
    g   = env_if.gate;
    ar  = longint'(env_if.attack_rate);
    dr  = longint'(env_if.decay_rate);
    rr  = longint'(env_if.release_rate);
    tgt = longint'(env_if.sustain_level) * 65536;
    p   = longint'($signed(env_if.wave)) * (m_level / 256);
    lvl = m_level;
    st  = m_state;
    if (g && !m_gq) begin
      st = S_ATT;
    end else if (!g && m_gq && (st == S_ATT || st == S_DEC || st == S_SUS)) begin
      st = S_REL;
    end else begin
      case (st)
        S_IDLE: lvl = 0;
        S_ATT: begin
          lvl = (ar == 0) ? longint'(LVL_MAX) : lvl + ar;
          if (lvl >= longint'(LVL_MAX)) begin
            lvl = longint'(LVL_MAX);
            st  = S_DEC;
          end
        end
        S_DEC: begin
          lvl = (dr == 0) ? tgt : lvl - dr;
          if (lvl <= tgt) begin
            lvl = tgt;
            st  = S_SUS;
          end
        end
        S_SUS: lvl = tgt;
        S_REL: begin
          lvl = (rr == 0) ? 0 : lvl - rr;
          if (lvl <= 0) begin
            lvl = 0;
            st  = S_IDLE;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_level = lvl;
    m_state = st;
    m_gq    = g;
    m_out   = 16'(p >>> 16);
  endtask

  task automatic test_reset();
    #12;
    total += 3;
    if (env_if.level !== 24'h0) begin bad++; $display("[TB] FAIL reset_level: got %h want 000000", env_if.level); end
    if (env_if.out !== 16'h0) begin bad++; $display("[TB] FAIL reset_out: got %h want 0000", env_if.out); end
    if (env_if.active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active: got %b want 0", env_if.active); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    env_if.gate        = 1'b1;
    env_if.attack_rate = 16'h8000;
    applyStimulus();
    for (int n = 0; n < 96; n++) begin
      env_if.wave = 16'($urandom);
      applyStimulus();
    end
    total++;
    if (env_if.level !== 24'h300000) begin bad++; $display("[TB] FAIL pre_reset_level: got %h want 300000", env_if.level); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total += 3;
    if (env_if.level !== 24'h0) begin bad++; $display("[TB] FAIL async_reset_level: got %h want 000000", env_if.level); end
    if (env_if.out !== 16'h0) begin bad++; $display("[TB] FAIL async_reset_out: got %h want 0000", env_if.out); end
    if (env_if.active !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_active: got %b want 0", env_if.active); end
    #1;
    rst_n = 1'b1;
    applyStimulus();
    total += 2;
    if (env_if.active !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_active: got %b want 1", env_if.active); end
    if (env_if.level !== 24'h0) begin bad++; $display("[TB] FAIL post_reset_level: got %h want 000000", env_if.level); end
    applyStimulus();
    total++;
    if (env_if.level !== 24'h008000) begin bad++; $display("[TB] FAIL post_reset_attack: got %h want 008000", env_if.level); end
    env_if.gate         = 1'b0;
    env_if.release_rate = 16'h0;
    applyStimulus();
    applyStimulus();
    total++;
    if (env_if.active !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle: got %b want 0", env_if.active); end
  endtask

  task automatic test_attack();
    logic [23:0] exp;
    env_if.attack_rate   = 16'h8000;
    env_if.decay_rate    = 16'h4000;
    env_if.sustain_level = 8'h80;
    env_if.gate          = 1'b1;
    applyStimulus();
    total++;
    if (env_if.level !== 24'h0) begin bad++; $display("[TB] FAIL attack_rise_level: got %h want 000000", env_if.level); end
    for (int n = 1; n <= 512; n++) begin
      env_if.wave = 16'($urandom);
      applyStimulus();
      exp = (n < 512) ? 24'(32'h8000 * n) : 24'hFFFFFF;
      total += 2;
      if (env_if.level !== exp) begin bad++; $display("[TB] FAIL attack_level n=%0d: got %h want %h", n, env_if.level, exp); end
      if (env_if.out !== m_out) begin bad++; $display("[TB] FAIL attack_out n=%0d: got %h want %h", n, env_if.out, m_out); end
    end
    applyStimulus();
    total++;
    if (env_if.level !== 24'hFFBFFF) begin bad++; $display("[TB] FAIL attack_to_decay: got %h want FFBFFF", env_if.level); end
  endtask

  task automatic test_decay_sustain();
    logic [23:0] exp;
    for (int k = 2; k <= 512; k++) begin
      env_if.wave = 16'($urandom);
      applyStimulus();
      exp = (k < 512) ? 24'(32'hFFFFFF - 32'h4000 * k) : 24'h800000;
      total += 2;
      if (env_if.level !== exp) begin bad++; $display("[TB] FAIL decay_level k=%0d: got %h want %h", k, env_if.level, exp); end
      if (env_if.out !== m_out) begin bad++; $display("[TB] FAIL decay_out k=%0d: got %h want %h", k, env_if.out, m_out); end
    end
    env_if.wave = 16'h7FFF;
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      total += 2;
      if (env_if.level !== 24'h800000) begin bad++; $display("[TB] FAIL sustain_hold: got %h want 800000", env_if.level); end
      if (env_if.out !== 16'h3FFF) begin bad++; $display("[TB] FAIL sustain_out: got %h want 3FFF", env_if.out); end
    end
    env_if.sustain_level = 8'h40;
    applyStimulus();
    total++;
    if (env_if.level !== 24'h400000) begin bad++; $display("[TB] FAIL sustain_track: got %h want 400000", env_if.level); end
    env_if.sustain_level = 8'h80;
    applyStimulus();
    total++;
    if (env_if.level !== 24'h800000) begin bad++; $display("[TB] FAIL sustain_restore: got %h want 800000", env_if.level); end
  endtask

  task automatic test_vca_extremes();
    env_if.gate         = 1'b0;
    env_if.release_rate = 16'h0;
    applyStimulus();
    applyStimulus();
    env_if.gate        = 1'b1;
    env_if.attack_rate = 16'h0;
    applyStimulus();
    applyStimulus();
    total++;
    if (env_if.level !== 24'hFFFFFF) begin bad++; $display("[TB] FAIL instant_attack: got %h want FFFFFF", env_if.level); end
    env_if.gate = 1'b0;
    env_if.wave = 16'h7FFF;
    applyStimulus();
    total += 2;
    if (env_if.out !== 16'h7FFE) begin bad++; $display("[TB] FAIL vca_pos_max: got %h want 7FFE", env_if.out); end
    if (env_if.level !== 24'hFFFFFF) begin bad++; $display("[TB] FAIL fall_keeps_level: got %h want FFFFFF", env_if.level); end
    env_if.gate = 1'b1;
    env_if.wave = 16'h8000;
    applyStimulus();
    total += 2;
    if (env_if.out !== 16'h8000) begin bad++; $display("[TB] FAIL vca_neg_max: got %h want 8000", env_if.out); end
    if (env_if.level !== 24'hFFFFFF) begin bad++; $display("[TB] FAIL rise_keeps_level: got %h want FFFFFF", env_if.level); end
    env_if.gate = 1'b0;
    applyStimulus();
    applyStimulus();
    for (int k = 0; k < 6; k++) begin
      env_if.wave = 16'($urandom);
      applyStimulus();
      total += 2;
      if (env_if.out !== 16'h0) begin bad++; $display("[TB] FAIL vca_zero_level: got %h want 0000", env_if.out); end
      if (env_if.active !== 1'b0) begin bad++; $display("[TB] FAIL idle_active: got %b want 0", env_if.active); end
    end
  endtask

  task automatic test_release();
    logic [23:0] exp;
    env_if.attack_rate   = 16'h0;
    env_if.decay_rate    = 16'h0;
    env_if.sustain_level = 8'h80;
    env_if.gate          = 1'b1;
    repeat (4) applyStimulus();
    total++;
    if (env_if.level !== 24'h800000) begin bad++; $display("[TB] FAIL release_setup: got %h want 800000", env_if.level); end
    env_if.release_rate = 16'h1000;
    env_if.gate         = 1'b0;
    applyStimulus();
    for (int k = 1; k <= 2048; k++) begin
      env_if.wave = 16'($urandom);
      applyStimulus();
      exp = 24'(32'h800000 - 32'h1000 * k);
      total += 2;
      if (env_if.level !== exp) begin bad++; $display("[TB] FAIL release_level k=%0d: got %h want %h", k, env_if.level, exp); end
      if (env_if.active !== (k < 2048)) begin bad++; $display("[TB] FAIL release_active k=%0d: got %b want %b", k, env_if.active, (k < 2048)); end
    end
    env_if.gate = 1'b1;
    repeat (3) applyStimulus();
    env_if.gate         = 1'b0;
    env_if.release_rate = 16'h0;
    applyStimulus();
    applyStimulus();
    total += 2;
    if (env_if.level !== 24'h0) begin bad++; $display("[TB] FAIL instant_release_level: got %h want 000000", env_if.level); end
    if (env_if.active !== 1'b0) begin bad++; $display("[TB] FAIL instant_release_active: got %b want 0", env_if.active); end
  endtask

  task automatic test_retrigger();
    env_if.gate = 1'b1;
    repeat (3) applyStimulus();
    env_if.release_rate = 16'h1000;
    env_if.gate         = 1'b0;
    applyStimulus();
    repeat (1024) applyStimulus();
    total++;
    if (env_if.level !== 24'h400000) begin bad++; $display("[TB] FAIL retrig_setup: got %h want 400000", env_if.level); end
    env_if.gate        = 1'b1;
    env_if.attack_rate = 16'hFFFF;
    applyStimulus();
    total += 2;
    if (env_if.level !== 24'h400000) begin bad++; $display("[TB] FAIL retrig_edge_level: got %h want 400000", env_if.level); end
    if (env_if.active !== 1'b1) begin bad++; $display("[TB] FAIL retrig_active: got %b want 1", env_if.active); end
    applyStimulus();
    total++;
    if (env_if.level !== 24'h40FFFF) begin bad++; $display("[TB] FAIL retrig_attack: got %h want 40FFFF", env_if.level); end
    env_if.gate = 1'b0;
    applyStimulus();
    env_if.gate = 1'b1;
    applyStimulus();
    total++;
    if (env_if.level !== 24'h40FFFF) begin bad++; $display("[TB] FAIL b2b_rise_level: got %h want 40FFFF", env_if.level); end
    env_if.gate = 1'b0;
    applyStimulus();
    total++;
    if (env_if.level !== 24'h40FFFF) begin bad++; $display("[TB] FAIL b2b_fall_level: got %h want 40FFFF", env_if.level); end
    applyStimulus();
    total++;
    if (env_if.level !== 24'h40EFFF) begin bad++; $display("[TB] FAIL b2b_release_step: got %h want 40EFFF", env_if.level); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) env_if.gate = ~env_if.gate;
      if ($urandom_range(0, 31) == 0) begin
        env_if.attack_rate   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(16'h0100, 16'hFFFF));
        env_if.decay_rate    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(16'h0100, 16'hFFFF));
        env_if.release_rate  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(16'h0100, 16'hFFFF));
        env_if.sustain_level = 8'($urandom);
      end
      env_if.wave = 16'($urandom);
      applyStimulus();
      total += 3;
      if (env_if.level !== 24'(m_level)) begin bad++; $display("[TB] FAIL random_level k=%0d: got %h want %h", k, env_if.level, 24'(m_level)); end
      if (env_if.out !== m_out) begin bad++; $display("[TB] FAIL random_out k=%0d: got %h want %h", k, env_if.out, m_out); end
      if (env_if.active !== (m_state != S_IDLE)) begin bad++; $display("[TB] FAIL random_active k=%0d: got %b want %b", k, env_if.active, (m_state != S_IDLE)); end
    end
  endtask

  initial begin
    rst_n                = 1'b0;
    env_if.gate          = 1'b0;
    env_if.attack_rate   = '0;
    env_if.decay_rate    = '0;
    env_if.sustain_level = '0;
    env_if.release_rate  = '0;
    env_if.wave          = '0;
    model_reset();
    test_reset();
    test_attack();
    test_decay_sustain();
    test_vca_extremes();
    test_release();
    test_retrigger();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
